// File: rtl/prco_decoder_if.sv
// prco_decoder_if: fetch <-> decode handshake plus decoded control bundle.
// Optional macro PRCO_DEC_ILLEGAL_TRAP_EN adds the sticky q_illegal flag.
interface prco_decoder_if;
  logic        i_en;
  logic        i_ce_dec;
  logic [15:0] i_instr;
  logic        q_ce_dec;
  logic        q_fetch_next;
  logic [2:0]  q_sela;
  logic [2:0]  q_selb;
  logic [2:0]  q_seld;
  logic [3:0]  q_alu_op;
  logic [15:0] q_imm;
  logic        q_use_imm;
  logic        q_we;
  logic        q_mem_rd;
  logic        q_mem_wr;
  logic        q_jmp;
  logic        q_busy;
  logic        q_halted;
  logic [15:0] q_icount;
`ifdef PRCO_DEC_ILLEGAL_TRAP_EN
  logic        q_illegal;

  modport master (
    output i_en, i_ce_dec, i_instr,
    input  q_ce_dec, q_fetch_next, q_sela, q_selb, q_seld, q_alu_op, q_imm,
           q_use_imm, q_we, q_mem_rd, q_mem_wr, q_jmp, q_busy, q_halted,
           q_icount, q_illegal
  );

  modport slave (
    input  i_en, i_ce_dec, i_instr,
    output q_ce_dec, q_fetch_next, q_sela, q_selb, q_seld, q_alu_op, q_imm,
           q_use_imm, q_we, q_mem_rd, q_mem_wr, q_jmp, q_busy, q_halted,
           q_icount, q_illegal
  );
`else
  modport master (
    output i_en, i_ce_dec, i_instr,
    input  q_ce_dec, q_fetch_next, q_sela, q_selb, q_seld, q_alu_op, q_imm,
           q_use_imm, q_we, q_mem_rd, q_mem_wr, q_jmp, q_busy, q_halted,
           q_icount
  );

  modport slave (
    input  i_en, i_ce_dec, i_instr,
    output q_ce_dec, q_fetch_next, q_sela, q_selb, q_seld, q_alu_op, q_imm,
           q_use_imm, q_we, q_mem_rd, q_mem_wr, q_jmp, q_busy, q_halted,
           q_icount
  );
`endif
endinterface

// File: rtl/prco_decoder.sv
// prco_decoder: PRCO instruction decode stage. Decodes 16-bit words into
// register selects / ALU op / immediate / controls, issues a one-cycle
// q_ce_dec strobe, fetches the second word of MOVW, latches HALT and counts
// issued instructions.
// Optional macro PRCO_DEC_ILLEGAL_TRAP_EN: illegal opcodes trap into the
// halted state and raise the sticky q_illegal flag; otherwise they issue as NOP.
module prco_decoder (
  input  logic          i_clk,
  input  logic          i_reset_n,
  prco_decoder_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_HALT} state_t;

  typedef enum logic [4:0] {
    OP_NOP  = 5'h00,
    OP_MOV  = 5'h01,
    OP_MOVI = 5'h02,
    OP_ADD  = 5'h03,
    OP_SUB  = 5'h04,
    OP_ADDI = 5'h05,
    OP_LDW  = 5'h06,
    OP_STW  = 5'h07,
    OP_JMP  = 5'h08,
    OP_CMP  = 5'h09,
    OP_MOVW = 5'h0A,
    OP_HALT = 5'h1F
  } opcode_t;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_PASSA = 4'd2;
  localparam logic [3:0] ALU_PASSB = 4'd3;
  localparam logic [3:0] ALU_NOP   = 4'd4;

  // Everything that is latched onto the outputs when an instruction issues
  typedef struct packed {
    logic [2:0] seld;
    logic [2:0] sela;
    logic [2:0] selb;
    logic [3:0] alu_op;
    logic       use_imm;
    logic       we;
    logic       mem_rd;
    logic       mem_wr;
    logic       jmp;
  } issue_t;

  state_t      state;
  issue_t      dec;
  issue_t      pend;
  issue_t      sel;
  logic [15:0] sel_imm;
  logic        is_halt;
  logic        is_two_word;
  logic        trap_hit;
  logic        issue;

  logic [4:0]  op;
  logic [2:0]  rd;
  logic [2:0]  ra;
  logic [2:0]  rb;

  assign op = bus.i_instr[15:11];
  assign rd = bus.i_instr[10:8];
  assign ra = bus.i_instr[7:5];
  assign rb = bus.i_instr[4:2];

  // Opcode decode of the current word; unknown opcodes fall through as NOP
  always_comb begin
    dec         = '0;
    dec.seld    = rd;
    dec.sela    = ra;
    dec.selb    = rb;
    dec.alu_op  = ALU_NOP;
    is_halt     = 1'b0;
    is_two_word = 1'b0;
    trap_hit    = 1'b0;
    case (op)
      OP_NOP: ;
      OP_MOV: begin
        dec.alu_op = ALU_PASSA;
        dec.we     = 1'b1;
      end
      OP_MOVI: begin
        dec.alu_op  = ALU_PASSB;
        dec.we      = 1'b1;
        dec.use_imm = 1'b1;
      end
      OP_ADD: begin
        dec.alu_op = ALU_ADD;
        dec.we     = 1'b1;
      end
      OP_SUB: begin
        dec.alu_op = ALU_SUB;
        dec.we     = 1'b1;
      end
      OP_ADDI: begin
        dec.alu_op  = ALU_ADD;
        dec.we      = 1'b1;
        dec.use_imm = 1'b1;
        dec.sela    = rd;
      end
      OP_LDW: begin
        dec.alu_op = ALU_ADD;
        dec.we     = 1'b1;
        dec.mem_rd = 1'b1;
      end
      OP_STW: begin
        dec.alu_op = ALU_ADD;
        dec.mem_wr = 1'b1;
        dec.selb   = rd;
      end
      OP_JMP: begin
        dec.alu_op  = ALU_PASSB;
        dec.jmp     = 1'b1;
        dec.use_imm = 1'b1;
      end
      OP_CMP: begin
        dec.alu_op = ALU_SUB;
      end
      OP_MOVW: begin
        dec.alu_op  = ALU_PASSB;
        dec.we      = 1'b1;
        dec.use_imm = 1'b1;
        is_two_word = 1'b1;
      end
      OP_HALT: begin
        is_halt = 1'b1;
      end
      default: begin
`ifdef PRCO_DEC_ILLEGAL_TRAP_EN
        trap_hit = 1'b1;
`endif
      end
    endcase
  end

  // In S_EXT the issued fields come from the held first word and the
  // immediate is the whole extension word; otherwise from the current word
  always_comb begin
    sel     = dec;
    sel_imm = {8'h00, bus.i_instr[7:0]};
    if (state == S_EXT) begin
      sel     = pend;
      sel_imm = bus.i_instr;
    end
  end

  // Issue happens on an accepted strobe that completes an instruction
  always_comb begin
    issue = 1'b0;
    if (bus.i_en && bus.i_ce_dec) begin
      if (state == S_EXT)
        issue = 1'b1;
      else if (state == S_IDLE)
        issue = !is_halt && !is_two_word && !trap_hit;
    end
  end

  // Decode FSM with registered outputs; i_en low freezes everything
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state            <= S_IDLE;
      pend             <= '0;
      bus.q_ce_dec     <= 1'b0;
      bus.q_fetch_next <= 1'b0;
      bus.q_seld       <= '0;
      bus.q_sela       <= '0;
      bus.q_selb       <= '0;
      bus.q_alu_op     <= ALU_NOP;
      bus.q_imm        <= '0;
      bus.q_use_imm    <= 1'b0;
      bus.q_we         <= 1'b0;
      bus.q_mem_rd     <= 1'b0;
      bus.q_mem_wr     <= 1'b0;
      bus.q_jmp        <= 1'b0;
      bus.q_busy       <= 1'b0;
      bus.q_halted     <= 1'b0;
      bus.q_icount     <= '0;
`ifdef PRCO_DEC_ILLEGAL_TRAP_EN
      bus.q_illegal    <= 1'b0;
`endif
    end else if (!bus.i_en) begin
      bus.q_ce_dec     <= 1'b0;
      bus.q_fetch_next <= 1'b0;
    end else begin
      bus.q_ce_dec     <= 1'b0;
      bus.q_fetch_next <= 1'b0;

      if (issue) begin
        bus.q_ce_dec  <= 1'b1;
        bus.q_seld    <= sel.seld;
        bus.q_sela    <= sel.sela;
        bus.q_selb    <= sel.selb;
        bus.q_alu_op  <= sel.alu_op;
        bus.q_imm     <= sel_imm;
        bus.q_use_imm <= sel.use_imm;
        bus.q_we      <= sel.we;
        bus.q_mem_rd  <= sel.mem_rd;
        bus.q_mem_wr  <= sel.mem_wr;
        bus.q_jmp     <= sel.jmp;
        bus.q_icount  <= bus.q_icount + 16'd1;
      end

      case (state)
        S_IDLE: begin
          if (bus.i_ce_dec) begin
            if (is_halt) begin
              state        <= S_HALT;
              bus.q_halted <= 1'b1;
            end else if (trap_hit) begin
              state        <= S_HALT;
              bus.q_halted <= 1'b1;
`ifdef PRCO_DEC_ILLEGAL_TRAP_EN
              bus.q_illegal <= 1'b1;
`endif
            end else if (is_two_word) begin
              state            <= S_EXT;
              pend             <= dec;
              bus.q_busy       <= 1'b1;
              bus.q_fetch_next <= 1'b1;
            end
          end
        end
        S_EXT: begin
          if (bus.i_ce_dec) begin
            state      <= S_IDLE;
            bus.q_busy <= 1'b0;
          end
        end
        S_HALT: ;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prco_decoder.sv
// tb_prco_decoder: directed vector table, icount wrap run and a randomized
// phase checked against an opcode-property reference model.
module tb_prco_decoder;

`ifdef PRCO_DEC_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  prco_decoder_if bus ();

  prco_decoder dut (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .bus      (bus)
  );

  typedef struct packed {
    logic        ce;
    logic        fn;
    logic [2:0]  seld;
    logic [2:0]  sela;
    logic [2:0]  selb;
    logic [3:0]  alu;
    logic [15:0] imm;
    logic        use_imm;
    logic        we;
    logic        mr;
    logic        mw;
    logic        jmp;
    logic        busy;
    logic        halted;
    logic        ill;
    logic [15:0] icount;
  } out_t;

  typedef struct {
    logic        r;
    logic        en;
    logic        ce;
    logic [15:0] w;
    out_t        exp;
  } vec_t;

  typedef struct {
    bit         valid;
    logic [3:0] alu;
    bit         we, use_imm, mr, mw, jmp, two;
    bit         sela_rd, selb_rd;
  } prop_t;

  int unsigned total = 0;
  int unsigned bad   = 0;
  vec_t        vecs[$];
  prop_t       props[32];

  out_t        m_out;
  bit          m_pend;
  bit          m_halt;
  logic [15:0] m_word;

  function automatic out_t mk(logic ce, logic fn, logic [2:0] sd, logic [2:0] sa,
                              logic [2:0] sb, logic [3:0] alu, logic [15:0] imm,
                              logic ui, logic we, logic mr, logic mw, logic jmp,
                              logic busy, logic halted, logic ill, logic [15:0] ic);
    out_t o;
    o = '{ce, fn, sd, sa, sb, alu, imm, ui, we, mr, mw, jmp, busy, halted, ill, ic};
    return o;
  endfunction

  function automatic out_t rst_out();
    out_t o;
    o = '0;
    o.alu = 4'd4;
    return o;
  endfunction

  function automatic out_t sample();
    out_t o;
    o.ce      = bus.q_ce_dec;
    o.fn      = bus.q_fetch_next;
    o.seld    = bus.q_seld;
    o.sela    = bus.q_sela;
    o.selb    = bus.q_selb;
    o.alu     = bus.q_alu_op;
    o.imm     = bus.q_imm;
    o.use_imm = bus.q_use_imm;
    o.we      = bus.q_we;
    o.mr      = bus.q_mem_rd;
    o.mw      = bus.q_mem_wr;
    o.jmp     = bus.q_jmp;
    o.busy    = bus.q_busy;
    o.halted  = bus.q_halted;
`ifdef PRCO_DEC_ILLEGAL_TRAP_EN
    o.ill     = bus.q_illegal;
`else
    o.ill     = 1'b0;
`endif
    o.icount  = bus.q_icount;
    return o;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // One clock: drive on the falling edge, sample 1 time unit after the rising edge
  task automatic cyc(input logic r, input logic en, input logic ce, input logic [15:0] w);
    @(negedge clk);
    rst_n        = r;
    bus.i_en     = en;
    bus.i_ce_dec = ce;
    bus.i_instr  = w;
    @(posedge clk);
    #1;
  endtask

  task automatic set_prop(input int op, input logic [3:0] alu, input bit we, input bit ui,
                          input bit mr, input bit mw, input bit jmp, input bit two,
                          input bit sard, input bit sbrd);
    props[op] = '{1'b1, alu, we, ui, mr, mw, jmp, two, sard, sbrd};
  endtask

  task automatic init_props();
    for (int i = 0; i < 32; i++)
      props[i] = '{1'b0, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    //        op    alu  we ui mr mw jmp two sa_rd sb_rd
    set_prop(8'h00, 4, 0, 0, 0, 0, 0, 0, 0, 0);
    set_prop(8'h01, 2, 1, 0, 0, 0, 0, 0, 0, 0);
    set_prop(8'h02, 3, 1, 1, 0, 0, 0, 0, 0, 0);
    set_prop(8'h03, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    set_prop(8'h04, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    set_prop(8'h05, 0, 1, 1, 0, 0, 0, 0, 1, 0);
    set_prop(8'h06, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    set_prop(8'h07, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    set_prop(8'h08, 3, 0, 1, 0, 0, 1, 0, 0, 0);
    set_prop(8'h09, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    set_prop(8'h0A, 3, 1, 1, 0, 0, 0, 1, 0, 0);
    set_prop(8'h1F, 4, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Model: an issued instruction takes its fields from the opcode word
  task automatic m_issue(input logic [15:0] word, input logic [15:0] imm);
    prop_t p;
    p = props[word[15:11]];
    m_out.ce      = 1'b1;
    m_out.seld    = word[10:8];
    m_out.sela    = p.sela_rd ? word[10:8] : word[7:5];
    m_out.selb    = p.selb_rd ? word[10:8] : word[4:2];
    m_out.alu     = p.alu;
    m_out.imm     = imm;
    m_out.use_imm = p.use_imm;
    m_out.we      = p.we;
    m_out.mr      = p.mr;
    m_out.mw      = p.mw;
    m_out.jmp     = p.jmp;
    m_out.icount  = m_out.icount + 16'd1;
  endtask

  task automatic m_step(input logic r, input logic en, input logic ce, input logic [15:0] w);
    if (!r) begin
      m_out  = rst_out();
      m_pend = 1'b0;
      m_halt = 1'b0;
    end else begin
      m_out.ce = 1'b0;
      m_out.fn = 1'b0;
      if (en && ce && !m_halt) begin
        if (m_pend) begin
          m_issue(m_word, w);
          m_pend     = 1'b0;
          m_out.busy = 1'b0;
        end else if (w[15:11] == 5'h1F) begin
          m_halt       = 1'b1;
          m_out.halted = 1'b1;
        end else if (TRAP && !props[w[15:11]].valid) begin
          m_halt       = 1'b1;
          m_out.halted = 1'b1;
          m_out.ill    = 1'b1;
        end else if (props[w[15:11]].two) begin
          m_pend     = 1'b1;
          m_word     = w;
          m_out.fn   = 1'b1;
          m_out.busy = 1'b1;
        end else begin
          m_issue(w, {8'h00, w[7:0]});
        end
      end
    end
  endtask

  task automatic add_vec(input logic r, input logic en, input logic ce, input logic [15:0] w,
                         input out_t exp);
    vec_t v;
    v = '{r, en, ce, w, exp};
    vecs.push_back(v);
  endtask

  initial begin
    out_t       e_add, e_movi, e_jmp, e_nop, e_tail;
    logic [15:0] w;
    logic [31:0] rnd;
    logic [4:0]  op;
    int          k;
    logic        r, en, ce;

    rst_n        = 1'b0;
    bus.i_en     = 1'b0;
    bus.i_ce_dec = 1'b0;
    bus.i_instr  = '0;
    init_props();

    //        ce fn sd sa sb alu imm       ui we mr mw j  bsy hlt il ic
    e_add  = mk(1, 0, 2, 2, 3, 0, 16'h004C, 0, 1, 0, 0, 0, 0, 0, 0, 16'd1);
    e_movi = mk(1, 0, 5, 5, 1, 3, 16'h00A5, 1, 1, 0, 0, 0, 0, 0, 0, 16'd2);
    e_jmp  = mk(1, 0, 0, 0, 4, 3, 16'h0012, 1, 0, 0, 0, 1, 0, 0, 0, 16'd7);
    e_nop  = mk(1, 0, 0, 0, 0, 4, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 16'd11);

    add_vec(0, 1, 0, 16'h0000, rst_out());
    add_vec(1, 1, 1, 16'h1A4C, e_add);
    e_add.ce = 0;
    add_vec(1, 1, 0, 16'h0000, e_add);
    add_vec(1, 1, 1, 16'h15A5, e_movi);
    e_movi.ce = 0; e_movi.fn = 1; e_movi.busy = 1;
    add_vec(1, 1, 1, 16'h5100, e_movi);
    e_movi.fn = 0;
    add_vec(1, 1, 0, 16'h0000, e_movi);
    add_vec(1, 0, 1, 16'hBEEF, e_movi);
    add_vec(1, 1, 1, 16'hBEEF, mk(1, 0, 1, 0, 0, 3, 16'hBEEF, 1, 1, 0, 0, 0, 0, 0, 0, 16'd3));
    add_vec(1, 1, 1, 16'h2B20, mk(1, 0, 3, 3, 0, 0, 16'h0020, 1, 1, 0, 0, 0, 0, 0, 0, 16'd4));
    add_vec(1, 1, 1, 16'h3C44, mk(1, 0, 4, 2, 4, 0, 16'h0044, 0, 0, 0, 1, 0, 0, 0, 0, 16'd5));
    add_vec(1, 1, 1, 16'h3268, mk(1, 0, 2, 3, 2, 0, 16'h0068, 0, 1, 1, 0, 0, 0, 0, 0, 16'd6));
    add_vec(1, 1, 1, 16'h4012, e_jmp);
    e_jmp.ce = 0;
    add_vec(1, 0, 1, 16'h1A4C, e_jmp);
    add_vec(1, 1, 1, 16'h4A4C, mk(1, 0, 2, 2, 3, 1, 16'h004C, 0, 0, 0, 0, 0, 0, 0, 0, 16'd8));
    add_vec(1, 1, 1, 16'h27E4, mk(1, 0, 7, 7, 1, 1, 16'h00E4, 0, 1, 0, 0, 0, 0, 0, 0, 16'd9));
    add_vec(1, 1, 1, 16'h0D84, mk(1, 0, 5, 4, 1, 2, 16'h0084, 0, 1, 0, 0, 0, 0, 0, 0, 16'd10));
    add_vec(1, 1, 1, 16'h0000, e_nop);
    e_add.ce = 1; e_add.icount = 16'd12;
    add_vec(1, 1, 1, 16'h1A4C, e_add);
    if (TRAP) begin
      e_tail = e_add;
      e_tail.ce = 0; e_tail.halted = 1; e_tail.ill = 1;
      add_vec(1, 1, 1, 16'h7800, e_tail);
    end else begin
      e_tail = e_nop;
      e_tail.icount = 16'd13;
      add_vec(1, 1, 1, 16'h7800, e_tail);
      e_tail.ce = 0; e_tail.halted = 1;
    end
    add_vec(1, 1, 1, 16'hF800, e_tail);
    add_vec(1, 1, 1, 16'h1A4C, e_tail);
    add_vec(0, 1, 0, 16'h0000, rst_out());
    e_tail = rst_out();
    e_tail.fn = 1; e_tail.busy = 1;
    add_vec(1, 1, 1, 16'h5100, e_tail);
    add_vec(0, 1, 1, 16'hBEEF, rst_out());
    e_add.icount = 16'd1;
    add_vec(1, 1, 1, 16'h1A4C, e_add);

    foreach (vecs[i]) begin
      cyc(vecs[i].r, vecs[i].en, vecs[i].ce, vecs[i].w);
      check($sformatf("vec%0d", i), 64'(sample()), 64'(vecs[i].exp));
    end

    // icount wrap with back-to-back ADDs
    cyc(0, 1, 0, 16'h0000);
    for (int i = 0; i < 65535; i++)
      cyc(1, 1, 1, 16'h1A4C);
    check("wrap_ffff", 64'(bus.q_icount), 64'h0000_0000_0000_FFFF);
    cyc(1, 1, 1, 16'h1A4C);
    check("wrap_zero", 64'(bus.q_icount), 64'h0);
    check("wrap_strobe", 64'(bus.q_ce_dec), 64'h1);

    // Randomized phase against the reference model
    cyc(0, 1, 0, 16'h0000);
    m_step(0, 1, 0, 16'h0000);
    check("rand_reset", 64'(sample()), 64'(m_out));
    for (int n = 0; n < 4000; n++) begin
      r   = ($urandom_range(0, 59) != 0);
      en  = ($urandom_range(0, 7) != 0);
      ce  = 1'($urandom_range(0, 1));
      rnd = $urandom();
      k   = $urandom_range(0, 99);
      if (k < 85)      op = 5'($urandom_range(0, 10));
      else if (k < 88) op = 5'h1F;
      else             op = 5'($urandom_range(0, 31));
      w = {op, rnd[10:0]};
      cyc(r, en, ce, w);
      m_step(r, en, ce, w);
      check($sformatf("rand%0d", n), 64'(sample()), 64'(m_out));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prco_decoder.md
# prco_decoder

Instruction decode stage of the PRCO core, sitting between instruction fetch and the register set. Accepts 16-bit instruction words, decodes them into register selects, ALU operation, immediate and write/memory controls, and issues a one-cycle `q_ce_dec` strobe that starts the register-read/ALU phase. Handles two-word instructions by requesting an extension word from fetch, latches HALT, and counts issued instructions.

## Interface
- No parameters; widths are fixed by the ISA: 16-bit word, 8 registers.
- `i_clk` in 1: core clock, all logic on rising edge.
- `i_reset_n` in 1: synchronous, active-low reset.
- `i_en` in 1: stage enable; low freezes all state and blocks strobes.
- `i_ce_dec` in 1: one-cycle strobe from fetch; `i_instr` is valid.
- `i_instr` in 16: instruction or extension word.
- `q_ce_dec` out 1: one-cycle issue strobe to the register set.
- `q_fetch_next` out 1: one-cycle request to fetch the extension word.
- `q_sela`, `q_selb`, `q_seld` out 3 each: source A, source B and destination selects.
- `q_alu_op` out 4: ALU operation code.
- `q_imm` out 16: immediate value; imm8 zero-extended, or imm16.
- `q_use_imm` out 1: ALU operand B comes from `q_imm`.
- `q_we` out 1: register write-back enable.
- `q_mem_rd`, `q_mem_wr`, `q_jmp` out 1 each: load, store and jump controls.
- `q_busy` out 1: high while in S_EXT.
- `q_halted` out 1: sticky HALT indication.
- `q_icount` out 16: count of issued instructions.
- `q_illegal` out 1: sticky illegal-opcode flag. Present only with `PRCO_DEC_ILLEGAL_TRAP_EN`.

## Operation
- Instruction format:
  - opcode [15:11]
  - rd [10:8]
  - ra [7:5]
  - rb [4:2]
  - imm8 [7:0]
- Opcode table (opcode → alu_op, controls):
  - NOP 0x00 → 4, no write.
  - MOV 0x01 → PASSA 2, we, sela=ra.
  - MOVI 0x02 → PASSB 3, we, use_imm.
  - ADD 0x03 → 0, we.
  - SUB 0x04 → 1, we.
  - ADDI 0x05 → 0, we, use_imm, sela=rd.
  - LDW 0x06 → 0, we, mem_rd.
  - STW 0x07 → 0, mem_wr, selb=rd.
  - JMP 0x08 → 3, jmp, use_imm.
  - CMP 0x09 → 1, no write.
  - MOVW 0x0A → 3, we, use_imm, two-word.
  - HALT 0x1F.
  - All other opcodes are illegal.
- Default field mapping: seld=rd, sela=ra, selb=rb, unless listed otherwise above.
- FSM states: S_IDLE, S_EXT, S_HALT.
  - S_IDLE + `i_ce_dec`, single-word opcode: latch the decoded fields, pulse `q_ce_dec`, increment `q_icount`, stay in S_IDLE.
  - S_IDLE + `i_ce_dec`, MOVW: latch rd, pulse `q_fetch_next`, go to S_EXT. No issue yet.
  - S_EXT + `i_ce_dec`: `q_imm` ← `i_instr`, pulse `q_ce_dec`, increment `q_icount`, return to S_IDLE.
  - HALT in S_IDLE: go to S_HALT, set `q_halted`=1. No issue, no count. Leave S_HALT only by reset.
  - S_HALT ignores `i_ce_dec`.
- `i_en` low: hold state and all latched outputs; force `q_ce_dec` and `q_fetch_next` to 0. An `i_ce_dec` arriving in that cycle is dropped.
- `q_icount` wraps 0xFFFF → 0x0000.
- Reset values:
  - All outputs 0, except `q_alu_op`=4 (NOP).
  - State S_IDLE.
  - Reset overrides every other input, including mid-S_EXT: the partially decoded MOVW is discarded.

## Timing
- Latency: `i_ce_dec` at edge N → `q_ce_dec` high for exactly the cycle after edge N. Decoded fields are valid in that same cycle and held until the next issue.
- MOVW: `q_fetch_next` is high for the cycle after the first word. `q_ce_dec` is high for the cycle after the extension word's `i_ce_dec`.
- `q_ce_dec` and `q_fetch_next` are never high in the same cycle. Each is always exactly one cycle wide.
- Back-to-back `i_ce_dec` on consecutive cycles is accepted: one issue per cycle.

## Configuration
- `PRCO_DEC_ILLEGAL_TRAP_EN` defined:
  - An illegal opcode sets `q_illegal`=1 (sticky) and enters S_HALT with `q_halted`=1.
  - No issue, no count.
  - An undefined opcode in the extension-word position is not checked.
- Not defined:
  - `q_illegal` port is absent.
  - An illegal opcode decodes as NOP: `q_ce_dec` pulses, `q_we`=0, `q_alu_op`=4, and `q_icount` increments.

## Test plan
- Reset, then `i_instr`=0x1A4C (ADD r2,r2,r3) → one cycle later:
  - `q_ce_dec`=1, `q_alu_op`=0.
  - `q_seld`=2, `q_sela`=2, `q_selb`=3, `q_we`=1.
  - `q_icount`=1.
- MOVI r5,0xA5 (0x15A5) → `q_imm`=0x00A5, `q_use_imm`=1, `q_seld`=5, `q_alu_op`=3.
- MOVW r1 (0x5100), then extension 0xBEEF:
  - `q_fetch_next` pulses once and `q_busy`=1.
  - Then `q_ce_dec` with `q_imm`=0xBEEF, `q_seld`=1.
  - Reset asserted between the two words → S_IDLE and no issue.
- HALT (0xF800), then ADD → `q_halted`=1; no further `q_ce_dec` and `q_icount` unchanged.
- Opcode 0x0F (0x7800):
  - Trap build: `q_illegal`=1, `q_halted`=1, no issue.
  - Non-trap build: NOP issue and count increments.
- `i_en`=0 with `i_ce_dec` pulsed → no strobe and no state change. Preload 0xFFFF issues (or run 65536 ADDs) → `q_icount` wraps to 0.
